// File: rtl/point_list_loader.sv
// point_list_loader: parses ASCII "X,Y\n" records from a byte stream and writes each pair to the coordinate memories
// Ports: clk, rst (async, active-high); start (session level); in_valid/in_data/in_last/in_ready (byte stream);
//        wr_en/wr_addr/wr_x/wr_y (memory write port); count (records written); done/error (session status)
module point_list_loader #(
  parameter int NUM_ELEMENTS = 496,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_x,
  output logic [DATA_WIDTH-1:0] wr_y,
  output logic [ADDR_WIDTH-1:0] count,
  output logic                  done,
  output logic                  error
);
  typedef enum logic [2:0] {IDLE, PARSE_X, PARSE_Y, FINISH, DONE, ERR} state_t;
  state_t state, state_n;
  logic [DATA_WIDTH-1:0] acc_x, acc_y, acc, acc_n;
  logic [7:0] d;
  logic seen_x, seen_y, py, fire, digit, skip, full, clr, upd, commit;
  assign in_ready = state == PARSE_X || state == PARSE_Y;
  assign done = state == DONE;
  assign error = state == ERR;
  assign fire = in_valid && in_ready;
  assign py = state == PARSE_Y;
  assign d = in_data - 8'h30;
  assign digit = in_data >= 8'h30 && in_data <= 8'h39;
  // CR, space, and a newline on an empty X field (blank line) are all no-ops
  assign skip = in_data == 8'h0D || in_data == 8'h20 || (in_data == 8'h0A && !py && !seen_x);
  assign full = count == ADDR_WIDTH'(NUM_ELEMENTS);
  assign acc = py ? acc_y : acc_x;
  assign acc_n = (acc << 3) + (acc << 1) + DATA_WIDTH'(d);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    clr = 1'b0;
    upd = 1'b0;
    commit = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_n = PARSE_X;
        clr = 1'b1;
      end
      PARSE_X, PARSE_Y: if (fire) begin
        if (digit) upd = 1'b1;
        else if (in_data == 8'h2C && !py && seen_x) state_n = PARSE_Y;
        else if (in_data == 8'h0A && py && seen_y) begin
          commit = 1'b1;
          state_n = PARSE_X;
        end
        else if (!skip) state_n = ERR;
        // end of stream: a complete Y field without its newline still counts as a record
        if (in_last && state_n != ERR) begin
          if (!commit && py && (seen_y || digit)) commit = 1'b1;
          state_n = (commit || (!py && !seen_x && !digit)) ? FINISH : ERR;
        end
        if (commit && full) begin
          commit = 1'b0;
          state_n = ERR;
        end
      end
      FINISH: state_n = DONE;
      DONE, ERR: if (!start) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_x <= '0;
      wr_y <= '0;
      count <= '0;
      acc_x <= '0;
      acc_y <= '0;
      seen_x <= 1'b0;
      seen_y <= 1'b0;
    end else begin
      wr_en <= commit;
      if (clr) begin
        count <= '0;
        acc_x <= '0;
        acc_y <= '0;
        seen_x <= 1'b0;
        seen_y <= 1'b0;
      end
      if (upd && py) begin
        acc_y <= acc_n;
        seen_y <= 1'b1;
      end
      if (upd && !py) begin
        acc_x <= acc_n;
        seen_x <= 1'b1;
      end
      // an implicit commit on a final digit must include that digit
      if (commit) begin
        wr_addr <= count;
        wr_x <= acc_x;
        wr_y <= digit ? acc_n : acc_y;
        count <= count + ADDR_WIDTH'(1);
        acc_x <= '0;
        acc_y <= '0;
        seen_x <= 1'b0;
        seen_y <= 1'b0;
      end
    end
endmodule
